// File: rtl/laser_echo_responder.sv
// laser_echo_responder
// Purpose: target emulator for the laser distance path. Watches the measurer's
//   act_laser strobe and, after a programmed time-of-flight in cycles, returns
//   a PULSE_W-cycle laser_reflect pulse.
// Latency: laser_reflect rises D cycles after the edge that samples the fire
//   edge, where D = max(dist_reg, 1) (plus 0..3 cycles when jitter is enabled).
// Backpressure: none; fire edges arriving while busy are dropped and flagged
//   on the sticky overrun output.
// Ports:
//   clk, rst                  sole clock, synchronous active-high reset
//   act_laser                 fire strobe (rising edge significant)
//   target_en                 1 = target present, 0 = open air (no echo)
//   dist_in, dist_load        new time-of-flight, captured on the load strobe
//   laser_reflect             registered echo pulse
//   busy                      shot in flight or echoing
//   overrun                   sticky: fire edge seen while busy
//   echo_count                echoes emitted, wraps at 256
// Optional feature macro: LASER_ECHO_JITTER_EN adds 0..3 cycles of LFSR jitter.
module laser_echo_responder #(
  parameter int CNT_W        = 16,
  parameter int PULSE_W      = 2,
  parameter int DEFAULT_DIST = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act_laser,
  input  logic             target_en,
  input  logic [CNT_W-1:0] dist_in,
  input  logic             dist_load,
  output logic             laser_reflect,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       echo_count
);

  localparam int PC_W = (PULSE_W < 2) ? 1 : $clog2(PULSE_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    ECHO   = 2'd2
  } state_t;

  state_t            state;
  logic              act_d;
  logic              fire;
  logic [CNT_W-1:0]  dist_reg;
  logic [CNT_W-1:0]  dist_eff;
  logic [CNT_W-1:0]  delay_next;
  logic [CNT_W-1:0]  delay_q;
  logic [CNT_W-1:0]  cnt;
  logic [PC_W-1:0]   pcnt;

  assign fire     = act_laser & ~act_d;
  // A zero distance would never match cnt (which starts at 1), so clamp to 1.
  assign dist_eff = (dist_reg == '0) ? CNT_W'(1) : dist_reg;

`ifdef LASER_ECHO_JITTER_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; free-running every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign delay_next = dist_eff + CNT_W'(lfsr[1:0]);
`else
  assign delay_next = dist_eff;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      act_d         <= 1'b0;
      dist_reg      <= CNT_W'(DEFAULT_DIST);
      delay_q       <= '0;
      cnt           <= '0;
      pcnt          <= '0;
      laser_reflect <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      echo_count    <= 8'd0;
    end else begin
      act_d <= act_laser;

      if (dist_load) begin
        dist_reg <= dist_in;
      end

      // A load clears overrun even if an overrun fire lands on the same edge.
      if (dist_load) begin
        overrun <= 1'b0;
      end else if (fire && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          laser_reflect <= 1'b0;
          busy          <= 1'b0;
          if (fire && target_en) begin
            delay_q <= delay_next;
            cnt     <= CNT_W'(1);
            busy    <= 1'b1;
            state   <= FLIGHT;
          end
        end

        FLIGHT: begin
          if (!target_en) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == delay_q) begin
            laser_reflect <= 1'b1;
            pcnt          <= PC_W'(1);
            echo_count    <= echo_count + 8'd1;
            state         <= ECHO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ECHO: begin
          // target_en is deliberately ignored: a started pulse always completes.
          if (pcnt == PC_W'(PULSE_W)) begin
            laser_reflect <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            pcnt <= pcnt + PC_W'(1);
          end
        end

        default: begin
          laser_reflect <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_echo_responder.sv
module tb_laser_echo_responder;

  localparam int CNT_W   = 16;
  localparam int PULSE_W = 2;
  localparam int DEF_D   = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             act_laser;
  logic             target_en;
  logic [CNT_W-1:0] dist_in;
  logic             dist_load;
  logic             laser_reflect;
  logic             busy;
  logic             overrun;
  logic [7:0]       echo_count;

  laser_echo_responder #(
    .CNT_W(CNT_W), .PULSE_W(PULSE_W), .DEFAULT_DIST(DEF_D)
  ) dut (
    .clk(clk), .rst(rst), .act_laser(act_laser), .target_en(target_en),
    .dist_in(dist_in), .dist_load(dist_load), .laser_reflect(laser_reflect),
    .busy(busy), .overrun(overrun), .echo_count(echo_count)
  );

  always #5 clk = ~clk;

  // cyc = index of the most recent rising edge, read at negedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int       rise_cyc;
    int       count;
  } echo_t;

  echo_t exp_q[$];

  // Reference model state
  int model_dist = DEF_D;
  int model_cnt  = 0;
  bit exp_ovr    = 0;
  bit mon_en     = 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expected echoes on each reflect rise and checks pulse width.
  bit prev_r = 0;
  int width  = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (laser_reflect && !prev_r) begin
        if (exp_q.size() == 0) begin
          check("unexpected_echo", 1, 0);
        end else begin
          echo_t e;
          e = exp_q.pop_front();
          check("echo_rise_cycle", cyc, e.rise_cyc);
          check("echo_count_at_rise", int'(echo_count), e.count);
        end
        width = 1;
      end else if (laser_reflect) begin
        width++;
      end else if (prev_r) begin
        check("pulse_width", width, PULSE_W);
      end
      prev_r = laser_reflect;
    end else begin
      prev_r = 1'b0;
      width  = 0;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic load(input int d);
    dist_in   = CNT_W'(d);
    dist_load = 1'b1;
    @(negedge clk);
    dist_load  = 1'b0;
    model_dist = d;
    exp_ovr    = 0;
    check("overrun_cleared_by_load", int'(overrun), 0);
  endtask

  // mode: 0 normal, 1 mid-shot reload, 2 overrun fire, 3 target drop, 4 fire with no target
  task automatic shot(input int mode, input bit do_load, input int d, input int d2);
    int dm, e0, r, k;
    if (do_load) load(d);
    dm = (model_dist == 0) ? 1 : model_dist;
    target_en = (mode != 4);
    act_laser = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    act_laser = 1'b0;
    check("busy_after_fire", int'(busy), (mode != 4) ? 1 : 0);
    if (mode != 3 && mode != 4) begin
      model_cnt = (model_cnt + 1) % 256;
      exp_q.push_back('{rise_cyc: e0 + dm, count: model_cnt});
    end
    case (mode)
      1: begin
        wait_cyc(e0 + 1);
        dist_in   = CNT_W'(d2);
        dist_load = 1'b1;
        @(negedge clk);
        dist_load  = 1'b0;
        model_dist = d2;
        exp_ovr    = 0;
      end
      2: begin
        r = $urandom_range(e0 + dm + PULSE_W, e0 + 2);
        wait_cyc(r - 1);
        act_laser = 1'b1;
        exp_ovr   = 1;
      end
      3: begin
        k = $urandom_range(dm, 1);
        wait_cyc(e0 + k - 1);
        target_en = 1'b0;
      end
      default: ;
    endcase
    if (mode == 0 || mode == 1 || mode == 2) begin
      wait_cyc(e0 + dm + PULSE_W - 1);
      check("busy_during_echo", int'(busy), 1);
    end
    wait_cyc(e0 + dm + PULSE_W);
    check("busy_after_shot", int'(busy), 0);
    check("reflect_after_shot", int'(laser_reflect), 0);
    act_laser = 1'b0;
    target_en = 1'b1;
    @(negedge clk);
    check("overrun_state", int'(overrun), exp_ovr ? 1 : 0);
    check("echo_count_total", int'(echo_count), model_cnt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, d;
    rst = 1'b1; act_laser = 1'b0; target_en = 1'b1; dist_in = '0; dist_load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_reflect", int'(laser_reflect), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_echo_count", int'(echo_count), 0);

    shot(0, 0, 0, 0);         // default distance 100
    shot(0, 1, 0, 0);         // zero distance clamps to 1
    shot(1, 1, 5, 50);        // reload mid-shot does not affect it
    shot(0, 0, 0, 0);         // ...but the next shot uses 50
    shot(2, 1, 20, 0);        // overrun fire
    load(7);                  // load clears overrun
    shot(3, 1, 30, 0);        // target drop aborts
    shot(4, 1, 30, 0);        // no target: never busy

    for (int i = 0; i < 250; i++) begin
      m = $urandom_range(4, 0);
      d = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(40, 1);
      shot(m, 1, d, $urandom_range(40, 0));
    end

    load(3);
    for (int i = 0; i < 256; i++) shot(0, 0, 0, 0);

    // Reset in the middle of an echo pulse.
    act_laser = 1'b1;
    begin
      int e0;
      e0 = cyc + 1;
      @(negedge clk);
      act_laser = 1'b0;
      wait_cyc(e0 + 3);
      check("reflect_before_rst", int'(laser_reflect), 1);
      mon_en = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    check("rst_mid_echo_reflect", int'(laser_reflect), 0);
    check("rst_mid_echo_busy", int'(busy), 0);
    check("rst_mid_echo_count", int'(echo_count), 0);
    check("rst_mid_echo_overrun", int'(overrun), 0);
    exp_q.delete();
    model_cnt  = 0;
    model_dist = DEF_D;
    exp_ovr    = 0;
    @(negedge clk);
    mon_en = 1;
    shot(0, 0, 0, 0);         // distance register back at default

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/laser_echo_responder.md
# laser_echo_responder

Target emulator for the laser distance measurement path: watches the measurer's `act_laser` strobe and, after a programmed time-of-flight in clock cycles, returns a `laser_reflect` pulse. It sits opposite the measurer in simulation benches and hardware-in-the-loop builds, standing in for the optics and target. This gives closed-loop, cycle-exact checking of measured distance.

## Interface
- `CNT_W`, 16: width of distance register and flight counter.
- `PULSE_W`, 2: `laser_reflect` high time in cycles; must be at least 1.
- `DEFAULT_DIST`, 100: distance loaded on reset; must be at least 1.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `act_laser`  in  1  laser fire strobe from the measurer; level input, rising edge is significant.
- `target_en`  in  1  1 = target present; 0 = no echo (models open air).
- `dist_in`  in  CNT_W  new time-of-flight in cycles.
- `dist_load`  in  1  1-cycle strobe: capture `dist_in`.
- `laser_reflect`  out  1  echo pulse to the measurer; registered.
- `busy`  out  1  a shot is in flight or echoing.
- `overrun`  out  1  sticky: a fire edge arrived while busy.
- `echo_count`  out  8  number of echoes emitted; wraps.

## Operation
- Edge detect: `fire = act_laser & ~act_d`, where `act_d` is `act_laser` registered. `act_d` resets to 0.
- `dist_reg` loads `dist_in` on `dist_load` in any state.
- Effective delay: `D = (dist_reg == 0) ? 1 : dist_reg`, latched into `delay_q` at fire.
- A `dist_load` during a shot does not affect that shot.
- **IDLE**
  - `busy=0`, `laser_reflect=0`.
  - On `fire & target_en`: latch `delay_q`, set `cnt<=1`, go to FLIGHT.
  - On `fire & ~target_en`: stay in IDLE, no other effect.
- **FLIGHT**
  - `busy=1`.
  - If `~target_en`: abort to IDLE. No pulse, no count.
  - Else if `cnt == delay_q`: go to ECHO, set `laser_reflect<=1`, `pcnt<=1`, `echo_count<=echo_count+1` (mod 256).
  - Otherwise `cnt<=cnt+1`.
- **ECHO**
  - `busy=1`, `laser_reflect=1`.
  - When `pcnt == PULSE_W`: `laser_reflect<=0`, go to IDLE.
  - Otherwise `pcnt<=pcnt+1`.
  - `target_en` is ignored here; a started pulse always completes.
- **Overrun**
  - A fire in FLIGHT or ECHO is ignored for timing and sets `overrun<=1`.
  - `overrun` clears only on `rst` or `dist_load`. If both occur in the same cycle as an overrun fire, `dist_load` wins and `overrun` ends at 0.
- A fire in the same cycle the FSM returns ECHO→IDLE counts as busy (overrun); it is not accepted.
- The counter is CNT_W wide; `cnt` never exceeds `delay_q`, so it does not wrap.

## Timing
- Reset values:
  - state IDLE
  - `laser_reflect=0`, `busy=0`, `overrun=0`, `echo_count=0`
  - `dist_reg=DEFAULT_DIST`, `act_d=0`
- Let edge E0 be the clock edge that samples `act_laser` 1 with `act_d` 0.
  - `busy` is high after E0.
  - `laser_reflect` rises after edge E0+D.
  - `laser_reflect` stays high for exactly PULSE_W cycles, then falls after E0+D+PULSE_W.
  - `busy` falls on the same edge as `laser_reflect`.
- The next shot can be accepted at edge E0+D+PULSE_W+1 at the earliest. `act_laser` must first return low for at least 1 sampled cycle.
- `rst` mid-shot: the next edge forces reset values; any pulse in progress is truncated.
- `echo_count` updates on the edge that raises `laser_reflect`.

## Configuration
- `LASER_ECHO_JITTER_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - At fire, `delay_q = D + lfsr[1:0]`, i.e. D..D+3.
- Not defined: no LFSR logic; `delay_q = D` exactly. All test plan values below assume undefined.

## Test plan
- Reset, then `act_laser` 0→1 at edge E0 with `target_en=1` and default distance 100 → `laser_reflect` high after E0+100 for 2 cycles; `echo_count=1`; `busy` high E0..E0+102.
- `dist_load` with `dist_in=0`, then fire → reflect after E0+1 (D clamped to 1).
- `dist_in=5`, fire, then `dist_load` with `dist_in=50` at E0+2 → echo still after E0+5; the next shot uses 50.
- `dist_in=20`, fire, second `act_laser` rise at E0+10 → single echo after E0+20; `overrun=1`; `overrun` returns to 0 after the next `dist_load`.
- `dist_in=30`, fire, drop `target_en` at E0+10 → no echo, state IDLE, `echo_count` unchanged. Fire with `target_en=0` → `busy` stays 0.
- 256 shots at distance 3 → `echo_count` wraps to 0. `rst` asserted mid-ECHO → `laser_reflect` low after that edge, all counters at 0.
